// File: rtl/button_ctrl.sv
// Memory-mapped multi-button controller: per-channel synchroniser, tick-sampled
// debouncer, sticky W1C press/release flags and a level interrupt request.
module button_ctrl #(
  parameter int unsigned N_BTN        = 3,
  parameter int unsigned SAMPLE_DIV   = 3,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic              ena,
  output logic [31:0]       buttonOut,
  output logic              irq
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [27:0] BASE_HI = BASE_ADDR[31:4];

  localparam logic [1:0] REG_LEVEL   = 2'd0;
  localparam logic [1:0] REG_PRESS   = 2'd1;
  localparam logic [1:0] REG_RELEASE = 2'd2;
  localparam logic [1:0] REG_IRQ_EN  = 2'd3;

  logic [N_BTN-1:0] sync_a_q;
  logic [N_BTN-1:0] sync_b_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick_c;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] rise_c;
  logic [N_BTN-1:0] fall_c;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] rel_q;
  logic [N_BTN-1:0] irq_en_q;
  logic [N_BTN-1:0] clr_press_c;
  logic [N_BTN-1:0] clr_rel_c;
  logic             wr_c;
  logic [1:0]       sel_c;
  logic             unused_bits;

  assign unused_bits = ^{addr[1:0], wdata};

  // Address decode: window match and register select
  assign ena   = (addr[31:4] == BASE_HI);
  assign sel_c = addr[3:2];
  assign wr_c  = ena & we;

  // Two-flop synchroniser for the raw asynchronous button levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= btn_in;
      sync_b_q <= sync_a_q;
    end
  end

  // Free-running sample divider; tick fires on the last count before wrap
  assign tick_c = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else if (tick_c) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // Debounce next-state: count consecutive differing ticks, flip on the last one
  always_comb begin
    level_d = level_q;
    rise_c  = '0;
    fall_c  = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_c) begin
        if (sync_b_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CNT - 1)) begin
          level_d[i] = sync_b_q[i];
          cnt_d[i]   = '0;
          rise_c[i]  = sync_b_q[i];
          fall_c[i]  = ~sync_b_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Write-one-to-clear masks for the sticky flag registers
  always_comb begin
    clr_press_c = '0;
    clr_rel_c   = '0;
    if (wr_c && (sel_c == REG_PRESS)) begin
      clr_press_c = wdata[N_BTN-1:0];
    end
    if (wr_c && (sel_c == REG_RELEASE)) begin
      clr_rel_c = wdata[N_BTN-1:0];
    end
  end

  // Sticky flags (a new edge beats a same-cycle clear), enable register and irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q  <= '0;
      rel_q    <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      press_q <= (press_q & ~clr_press_c) | rise_c;
      rel_q   <= (rel_q & ~clr_rel_c) | fall_c;
      if (wr_c && (sel_c == REG_IRQ_EN)) begin
        irq_en_q <= wdata[N_BTN-1:0];
      end
      irq <= |((press_q | rel_q) & irq_en_q);
    end
  end

  // Read mux; decoded from addr[3:2] regardless of ena
  always_comb begin
    buttonOut = '0;
    case (sel_c)
      REG_LEVEL:   buttonOut = 32'(level_q);
      REG_PRESS:   buttonOut = 32'(press_q);
      REG_RELEASE: buttonOut = 32'(rel_q);
      REG_IRQ_EN:  buttonOut = 32'(irq_en_q);
      default:     buttonOut = '0;
    endcase
  end

endmodule
